// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags,
// synchronous clear and sticky overflow/underflow error flags.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             wr_ok;
  logic             rd_ok;

  // Flags decode the count register only, never the live requests.
  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_empty = (count <= CW'(AE_LEVEL));
  assign almost_full  = (count >= CW'(AF_LEVEL));

  // A clear cycle swallows both requests, including the memory write.
  assign wr_ok = wr & ~full  & ~clr;
  assign rd_ok = rd & ~empty & ~clr;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (rd_ok) begin
        rptr <= rptr + AW'(1);
        dout <= mem[rptr];
      end
      if (wr_ok && !rd_ok) begin
        count <= count + CW'(1);
      end else if (rd_ok && !wr_ok) begin
        count <= count - CW'(1);
      end
      if (wr && full) begin
        overflow <= 1'b1;
      end
      if (rd && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
